// File: rtl/score_pkg.sv
// Shared types and constants for the score BCD converter.
// Holds the FSM state type, the blank digit code and constant helpers.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Decimal digits needed to hold 2^w-1 without loss.
    function automatic int unsigned bcd_digits(input int unsigned w);
        longint unsigned maxv;
        int unsigned     n;
        maxv = (64'd1 << w) - 64'd1;
        n    = 1;
        while (maxv >= pow10(n)) n++;
        return n;
    endfunction

endpackage

// File: rtl/score_bcd_converter_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) o_nib = i_nib + 4'd3;
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Multi-channel binary-to-BCD score converter (serial double-dabble, one channel at a time).
// Optional macro SCORE_BLANK_EN: leading-zero digits are committed as the blank code.
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NCH*WIDTH-1:0]     value,
    output logic                     busy,
    output logic                     done,
    output logic [NCH*DIGITS*4-1:0]  digits,
    output logic [NCH-1:0]           ovf
);

    localparam int          ACC_DIG = int'(bcd_digits(WIDTH));
    localparam int          ACC_W   = ACC_DIG * 4;
    localparam int          PAD_W   = (DIGITS * 4 > ACC_W) ? DIGITS * 4 : ACC_W;
    localparam int          CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          CNT_W   = $clog2(WIDTH + 1);
    localparam logic [63:0] SAT     = 64'(pow10(DIGITS));

    state_t                    r_state, w_next;
    logic [NCH*WIDTH-1:0]      r_snap;
    logic [NCH*WIDTH-1:0]      w_snap_nxt;
    logic [WIDTH-1:0]          r_shreg;
    logic [ACC_W-1:0]          r_acc;
    logic [ACC_W-1:0]          w_adj;
    logic [PAD_W-1:0]          w_acc_pad;
    logic [CH_W-1:0]           r_ch;
    logic [CNT_W-1:0]          r_cnt;
    logic [NCH*DIGITS*4-1:0]   r_sh_dig;
    logic [NCH-1:0]            r_sh_ovf;
    logic [DIGITS*4-1:0]       w_ch_digits;
    logic [NCH*DIGITS*4-1:0]   w_commit;
    logic [NCH*DIGITS*4-1:0]   r_digits;
    logic [NCH-1:0]            r_ovf;
    logic                      r_done;
    logic [WIDTH-1:0]          w_chval;
    logic                      w_sat;
    logic                      w_last_bit;
    logic                      w_last_ch;
    logic                      w_unused_acc;

    for (genvar n = 0; n < ACC_DIG; n++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_acc[n*4 +: 4]),
            .o_nib (w_adj[n*4 +: 4])
        );
    end

    // The snapshot is shifted down one channel per STORE, so the current channel is always at the bottom.
    assign w_chval      = r_snap[WIDTH-1:0];
    assign w_snap_nxt   = r_snap >> WIDTH;
    assign w_sat        = (64'(w_chval) >= SAT);
    assign w_acc_pad    = PAD_W'(r_acc);
    assign w_last_bit   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_last_ch    = (r_ch == CH_W'(NCH - 1));
    assign w_unused_acc = ^{w_acc_pad, w_adj[ACC_W-1]};

    always_comb begin
        w_ch_digits = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            w_ch_digits[d*4 +: 4] = w_sat ? 4'd9 : w_acc_pad[d*4 +: 4];
        end
    end

`ifdef SCORE_BLANK_EN
    logic w_lead;

    always_comb begin
        w_commit = r_sh_dig;
        w_lead   = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_lead = !r_sh_ovf[c];
            for (int unsigned k = 0; k < DIGITS - 1; k++) begin
                if (w_lead && r_sh_dig[(c*DIGITS + DIGITS - 1 - k)*4 +: 4] == 4'd0)
                    w_commit[(c*DIGITS + DIGITS - 1 - k)*4 +: 4] = BCD_BLANK;
                else
                    w_lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_commit = r_sh_dig;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_next = S_STORE;
            S_STORE: w_next = w_last_ch ? S_DONE : S_SHIFT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap   <= '0;
            r_shreg  <= '0;
            r_acc    <= '0;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_sh_dig <= '0;
            r_sh_ovf <= '0;
            r_digits <= '0;
            r_ovf    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snap  <= value;
                        r_shreg <= value[WIDTH-1:0];
                        r_acc   <= '0;
                        r_ch    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_acc   <= {w_adj[ACC_W-2:0], r_shreg[WIDTH-1]};
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_STORE: begin
                    r_sh_dig[int'(r_ch)*DIGITS*4 +: DIGITS*4] <= w_ch_digits;
                    r_sh_ovf[r_ch]                           <= w_sat;
                    if (!w_last_ch) begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_snap  <= w_snap_nxt;
                        r_shreg <= w_snap_nxt[WIDTH-1:0];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_DONE: begin
                    r_digits <= w_commit;
                    r_ovf    <= r_sh_ovf;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign digits = r_digits;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: random and directed conversions against a decimal model.
module tb_score_bcd_converter;

    localparam int NCH      = 2;
    localparam int WIDTH    = 10;
    localparam int DIGITS   = 3;
    localparam int LAT      = NCH * (WIDTH + 1) + 1;
    localparam int NCH_B    = 4;
    localparam int WIDTH_B  = 14;
    localparam int DIGITS_B = 4;
    localparam int LAT_B    = NCH_B * (WIDTH_B + 1) + 1;

    logic clk = 1'b0;
    logic reset, start, start_b;
    logic busy, done, busy_b, done_b;
    logic [NCH*WIDTH-1:0]        value;
    logic [NCH*DIGITS*4-1:0]     digits;
    logic [NCH-1:0]              ovf;
    logic [NCH_B*WIDTH_B-1:0]    value_b;
    logic [NCH_B*DIGITS_B*4-1:0] digits_b;
    logic [NCH_B-1:0]            ovf_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    score_bcd_converter #(.NCH(NCH), .WIDTH(WIDTH), .DIGITS(DIGITS)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .digits (digits),
        .ovf    (ovf)
    );

    score_bcd_converter #(.NCH(NCH_B), .WIDTH(WIDTH_B), .DIGITS(DIGITS_B)) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .start  (start_b),
        .value  (value_b),
        .busy   (busy_b),
        .done   (done_b),
        .digits (digits_b),
        .ovf    (ovf_b)
    );

    function automatic longint unsigned ten_to(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] model_chan(input longint unsigned v, input int unsigned digs);
        logic [31:0]     r;
        longint unsigned p;
        logic            blank;
        r = '0;
        p = 1;
        for (int unsigned d = 0; d < digs; d++) begin
            blank = 1'b0;
`ifdef SCORE_BLANK_EN
            blank = (d > 0) && (v < p);
`endif
            if (v >= ten_to(digs))  r[d*4 +: 4] = 4'd9;
            else if (blank)         r[d*4 +: 4] = 4'hF;
            else                    r[d*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] model_digits(input logic [63:0] v, input int unsigned nch,
                                                 input int unsigned width, input int unsigned digs);
        logic [63:0]     r;
        logic [31:0]     ch;
        longint unsigned cv;
        r = '0;
        for (int unsigned c = 0; c < nch; c++) begin
            cv = (v >> (c * width)) & ((64'd1 << width) - 64'd1);
            ch = model_chan(cv, digs);
            for (int unsigned d = 0; d < digs; d++) r[(c*digs + d)*4 +: 4] = ch[d*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [63:0] model_ovf(input logic [63:0] v, input int unsigned nch,
                                              input int unsigned width, input int unsigned digs);
        logic [63:0]     r;
        longint unsigned cv;
        r = '0;
        for (int unsigned c = 0; c < nch; c++) begin
            cv   = (v >> (c * width)) & ((64'd1 << width) - 64'd1);
            r[c] = (cv >= ten_to(digs));
        end
        return r;
    endfunction

    function automatic logic [9:0] pick10();
        case ($urandom_range(0, 5))
            0:       return 10'd0;
            1:       return 10'd999;
            2:       return 10'd1000;
            3:       return 10'd1023;
            default: return 10'($urandom_range(0, 1023));
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one conversion; optionally change value and re-pulse start mid-flight.
    task automatic run_a(input logic [NCH*WIDTH-1:0] v, input bit disturb,
                         output int lat, output int bcnt);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = int'(busy);
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (disturb && lat == 4) begin
                value = ~v;
                start = 1'b1;
            end
            if (disturb && lat == 5) start = 1'b0;
            if (done !== 1'b1 && busy === 1'b1) bcnt++;
        end
    endtask

    task automatic do_conv(input logic [NCH*WIDTH-1:0] v, input bit disturb, input string tag);
        int lat, bcnt, extra;
        run_a(v, disturb, lat, bcnt);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(LAT));
        check({tag, "_digits"}, 64'(digits), model_digits(64'(v), NCH, WIDTH, DIGITS));
        check({tag, "_ovf"}, 64'(ovf), model_ovf(64'(v), NCH, WIDTH, DIGITS));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        if (disturb) begin
            extra = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) extra++;
            end
            check({tag, "_no_extra_done"}, 64'(extra), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold"}, 64'(digits), model_digits(64'(v), NCH, WIDTH, DIGITS));
    endtask

    initial begin
        logic [NCH*WIDTH-1:0] v, v2;
        int n, gap, ndone;

        reset   = 1'b1;
        start   = 1'b0;
        start_b = 1'b0;
        value   = '0;
        value_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_digits", 64'(digits), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_digits_b", 64'(digits_b), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_conv({10'd0, 10'd0}, 1'b0, "zero");
        do_conv({10'd1023, 10'd999}, 1'b0, "sat");
        do_conv({10'd7, 10'd305}, 1'b0, "mixed");
        do_conv({10'd1000, 10'd1}, 1'b1, "snapshot");

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_conv({pick10(), pick10()}, 1'b0, "rand");
        end

        // Abort mid-conversion with reset after leaving non-zero committed results.
        do_conv({10'd1023, 10'd1023}, 1'b0, "pre_abort");
        @(negedge clk);
        value = {10'd5, 10'd6};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_digits", 64'(digits), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_conv({10'd88, 10'd640}, 1'b0, "post_abort");

        // Start held high: back-to-back conversions, second one sees the updated value.
        v  = {pick10(), pick10()};
        v2 = {pick10(), pick10()};
        @(negedge clk);
        value = v;
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_first_digits", 64'(digits), model_digits(64'(v), NCH, WIDTH, DIGITS));
        value = v2;
        gap   = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (done !== 1'b1 && gap < 200);
        start = 1'b0;
        check("hold_gap", 64'(gap), 64'(LAT + 1));
        check("hold_second_digits", 64'(digits), model_digits(64'(v2), NCH, WIDTH, DIGITS));
        check("hold_second_ovf", 64'(ovf), model_ovf(64'(v2), NCH, WIDTH, DIGITS));

        // Wider configuration.
        @(negedge clk);
        value_b = {14'd9999, 14'd10000, 14'd42, 14'd1};
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b_latency", 64'(n), 64'(LAT_B));
        check("b_digits", 64'(digits_b), model_digits(64'(value_b), NCH_B, WIDTH_B, DIGITS_B));
        check("b_ovf", 64'(ovf_b), 64'b0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
